mux_arbiter: RTL and testbench

- Round-robin arbiter/sequencer that shares one W-bit output channel between N requesters by driving the select of a shared N:1 data mux.
- Each requester presents data with a valid/ready handshake. The winner holds the channel for up to MAX_BURST beats, then priority rotates.
- Output is a single registered stage; it sits between several producers and one consumer channel.

---
 rtl/mux_arbiter_pkg.sv | 14 +
 rtl/mux_arbiter_if.sv | 26 ++
 rtl/mux_arbiter_rr_pick.sv | 30 +++
 rtl/mux_arbiter.sv | 119 +++++++++++
 tb/tb_mux_arbiter.sv | 253 +++++++++++++++++++++++++
 5 files changed

// File: rtl/mux_arbiter_pkg.sv
// Shared types and helpers for the round-robin mux arbiter.
package mux_arbiter_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  // Next requester index with wrap-around from n-1 back to 0.
  function automatic int unsigned wrap_inc(input int unsigned idx, input int unsigned n);
    return (idx + 32'd1 >= n) ? 32'd0 : idx + 32'd1;
  endfunction

endpackage

// File: rtl/mux_arbiter_if.sv
// Producer/consumer handshake bundle around the shared output channel.
// master: the side that drives requests and consumes the output (producers + sink).
// slave:  the arbiter itself.
interface mux_arbiter_if #(
  parameter int N = 2,
  parameter int W = 8
);

  logic [N-1:0]   in_valid;
  logic [N*W-1:0] in_data;
  logic [N-1:0]   in_ready;
  logic           out_valid;
  logic [W-1:0]   out_data;
  logic           out_ready;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );

endinterface

// File: rtl/mux_arbiter_rr_pick.sv
// Combinational round-robin scan: first asserted req starting at ptr, wrapping.
module mux_arbiter_rr_pick
  import mux_arbiter_pkg::*;
#(
  parameter int  N   = 2,
  localparam int IDW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]   req,
  input  logic [IDW-1:0] ptr,
  output logic [IDW-1:0] idx,
  output logic           any
);

  logic [IDW-1:0] cand;

  // Walk ptr, ptr+1, ... mod N and keep the first requester found.
  always_comb begin
    idx  = '0;
    any  = 1'b0;
    cand = ptr;
    for (int i = 0; i < N; i++) begin
      if (!any && req[cand]) begin
        any = 1'b1;
        idx = cand;
      end
      cand = IDW'(wrap_inc(32'(cand), N));
    end
  end

endmodule

// File: rtl/mux_arbiter.sv
// Round-robin arbiter sharing one registered W-bit output channel between
// N valid/ready requesters, with a per-grant burst limit.
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   IDLE  | no owner; pick next requester from prio_ptr (1-cycle cost)
//   GRANT | grant_id owns the channel until burst limit or it drops valid
module mux_arbiter
  import mux_arbiter_pkg::*;
#(
  parameter int  N         = 2,
  parameter int  W         = 8,
  parameter int  MAX_BURST = 4,
  localparam int IDW       = (N > 1) ? $clog2(N) : 1
) (
  input  logic           clk,
  input  logic           rst,
  mux_arbiter_if.slave   bus,
  output logic [IDW-1:0] grant_id,
  output logic           busy
);

  localparam int BW = $clog2(MAX_BURST + 1);

  state_t         state_q, state_d;
  logic [IDW-1:0] prio_ptr;
  logic [IDW-1:0] pick_idx;
  logic           pick_any;
  logic [BW-1:0]  beat_cnt;
  logic           out_valid_q;
  logic [W-1:0]   out_data_q;
  logic [W-1:0]   data_arr [N];
  logic [W-1:0]   sel_data;
  logic           sel_valid;
  logic           out_space;
  logic           xfer;
  logic           rel;
  logic [N-1:0]   in_ready_c;

  mux_arbiter_rr_pick #(.N(N)) u_pick (
    .req (bus.in_valid),
    .ptr (prio_ptr),
    .idx (pick_idx),
    .any (pick_any)
  );

  for (genvar k = 0; k < N; k++) begin : g_slice
    assign data_arr[k] = bus.in_data[k*W +: W];
  end

  assign sel_valid = bus.in_valid[grant_id];
  assign sel_data  = data_arr[grant_id];

  // Output register can take a new beat if empty or being drained this cycle.
  assign out_space = !out_valid_q || bus.out_ready;

  // Next state, ready decode and transfer/release qualification.
  always_comb begin
    state_d    = state_q;
    in_ready_c = '0;
    xfer       = 1'b0;
    rel        = 1'b0;
    case (state_q)
      IDLE: begin
        if (pick_any) state_d = GRANT;
      end
      GRANT: begin
        in_ready_c[grant_id] = out_space;
        if (!sel_valid) begin
          rel     = 1'b1;
          state_d = IDLE;
        end else if (out_space) begin
          xfer = 1'b1;
          if (beat_cnt == BW'(MAX_BURST - 1)) begin
            rel     = 1'b1;
            state_d = IDLE;
          end
        end
      end
    endcase
  end

  // State, grant latch, beat counting and priority rotation.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      prio_ptr <= '0;
      grant_id <= '0;
      beat_cnt <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && pick_any) begin
        grant_id <= pick_idx;
        beat_cnt <= '0;
      end
      if (xfer) beat_cnt <= beat_cnt + 1'b1;
      if (rel)  prio_ptr <= IDW'(wrap_inc(32'(grant_id), N));
    end
  end

  // Registered output stage; refill on transfer, otherwise drain on out_ready.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else if (xfer) begin
      out_valid_q <= 1'b1;
      out_data_q  <= sel_data;
    end else if (bus.out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign busy          = (state_q == GRANT);

endmodule

// File: tb/tb_mux_arbiter.sv
// Self-checking bench for mux_arbiter (N=4, W=8, MAX_BURST=4).
module tb_mux_arbiter;

  localparam int N  = 4;
  localparam int W  = 8;
  localparam int MB = 4;
  localparam int GW = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [GW-1:0] grant_id;
  logic          busy;

  mux_arbiter_if #(.N(N), .W(W)) bus ();

  mux_arbiter #(.N(N), .W(W), .MAX_BURST(MB)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .grant_id (grant_id),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  int nchk = 0;
  int nerr = 0;

  // Reference model: owner, rotation pointer, beats in this grant, output reg.
  bit           m_busy = 0;
  bit           m_ov   = 0;
  int           m_gid  = 0;
  int           m_ptr  = 0;
  int           m_beats = 0;
  logic [W-1:0] m_od   = '0;
  logic [N-1:0] exp_ready, act_ready;

  // Requester k presents base[k] + number of beats it has already handed over.
  int           cnt  [N];
  logic [W-1:0] base [N];

  task automatic drive_data();
    for (int k = 0; k < N; k++) bus.in_data[k*W +: W] = base[k] + W'(cnt[k]);
  endtask

  task automatic set_base(input logic [W*N-1:0] b);
    for (int k = 0; k < N; k++) begin
      base[k] = b[k*W +: W];
      cnt[k]  = 0;
    end
    drive_data();
  endtask

  // One clock: sample in_ready before the edge, advance the model on the edge.
  task automatic step();
    bit xf;
    #4;
    act_ready = bus.in_ready;
    exp_ready = '0;
    if (m_busy) exp_ready[m_gid] = !m_ov || bus.out_ready;
    @(posedge clk);
    if (rst) begin
      m_busy = 0; m_ptr = 0; m_gid = 0; m_beats = 0; m_ov = 0; m_od = '0;
    end else if (!m_busy) begin
      if (bus.out_ready) m_ov = 0;
      for (int k = 0; k < N; k++) begin
        int j;
        j = (m_ptr + k) % N;
        if (bus.in_valid[j]) begin
          m_gid = j; m_beats = 0; m_busy = 1;
          break;
        end
      end
    end else begin
      xf = bus.in_valid[m_gid] && exp_ready[m_gid];
      if (xf) begin
        m_od = bus.in_data[m_gid*W +: W];
        m_ov = 1;
        m_beats++;
        cnt[m_gid]++;
      end else if (bus.out_ready) begin
        m_ov = 0;
      end
      if (!bus.in_valid[m_gid] || m_beats == MB) begin
        m_busy = 0;
        m_ptr  = (m_gid + 1) % N;
      end
    end
    #1;
    drive_data();
  endtask

  task automatic fresh_reset();
    rst = 1; bus.in_valid = '0; bus.out_ready = 1;
    step();
    rst = 0;
  endtask

  task automatic test_reset();
    rst = 1; bus.in_valid = '1; bus.out_ready = 1;
    set_base({8'h70, 8'h50, 8'h30, 8'h10});
    step(); step();
    nchk++; if (bus.out_valid !== 1'b0) begin nerr++; $display("FAIL reset_out_valid: got %b expected 0", bus.out_valid); end
    nchk++; if (bus.out_data !== 8'h00) begin nerr++; $display("FAIL reset_out_data: got %h expected 00", bus.out_data); end
    nchk++; if (grant_id !== 2'd0) begin nerr++; $display("FAIL reset_grant_id: got %0d expected 0", grant_id); end
    nchk++; if (busy !== 1'b0) begin nerr++; $display("FAIL reset_busy: got %b expected 0", busy); end
    rst = 0;
    step();
    nchk++; if (act_ready !== 4'b0000) begin nerr++; $display("FAIL reset_in_ready: got %b expected 0000", act_ready); end
    nchk++; if (busy !== 1'b1 || grant_id !== 2'd0) begin nerr++; $display("FAIL first_grant: got busy=%b id=%0d expected busy=1 id=0", busy, grant_id); end
  endtask

  task automatic test_burst_limit();
    bit           ov_t [11] = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0, 1};
    logic [W-1:0] od_t [11] = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h00, 8'h20, 8'h21, 8'h22, 8'h23, 8'h00, 8'h14};
    set_base({8'h00, 8'h00, 8'h20, 8'h10});
    fresh_reset();
    bus.in_valid = 4'b0011;
    step();
    for (int i = 0; i < 11; i++) begin
      step();
      nchk++; if (bus.out_valid !== ov_t[i]) begin nerr++; $display("FAIL burst_valid[%0d]: got %b expected %b", i, bus.out_valid, ov_t[i]); end
      if (ov_t[i]) begin
        nchk++; if (bus.out_data !== od_t[i]) begin nerr++; $display("FAIL burst_data[%0d]: got %h expected %h", i, bus.out_data, od_t[i]); end
      end
      nchk++; if (act_ready !== exp_ready) begin nerr++; $display("FAIL burst_ready[%0d]: got %b expected %b", i, act_ready, exp_ready); end
    end
    nchk++; if (grant_id !== 2'd0) begin nerr++; $display("FAIL burst_back_to_0: got %0d expected 0", grant_id); end
  endtask

  task automatic test_voluntary();
    set_base({8'h00, 8'h00, 8'hA0, 8'h00});
    fresh_reset();
    bus.in_valid = 4'b0010;
    step();
    nchk++; if (grant_id !== 2'd1 || busy !== 1'b1) begin nerr++; $display("FAIL vol_grant: got id=%0d busy=%b expected id=1 busy=1", grant_id, busy); end
    step();
    nchk++; if (bus.out_data !== 8'hA0 || bus.out_valid !== 1'b1) begin nerr++; $display("FAIL vol_beat0: got %h/%b expected a0/1", bus.out_data, bus.out_valid); end
    step();
    nchk++; if (bus.out_data !== 8'hA1 || bus.out_valid !== 1'b1) begin nerr++; $display("FAIL vol_beat1: got %h/%b expected a1/1", bus.out_data, bus.out_valid); end
    bus.in_valid = 4'b0000;
    step();
    nchk++; if (busy !== 1'b0 || bus.out_valid !== 1'b0) begin nerr++; $display("FAIL vol_release: got busy=%b ov=%b expected 0/0", busy, bus.out_valid); end
    bus.in_valid = 4'b0011;
    step();
    nchk++; if (grant_id !== 2'd0 || busy !== 1'b1) begin nerr++; $display("FAIL vol_regrant: got id=%0d busy=%b expected id=0 busy=1", grant_id, busy); end
  endtask

  task automatic test_backpressure();
    bit           ov_t [4] = '{1, 1, 0, 1};
    logic [W-1:0] od_t [4] = '{8'h32, 8'h33, 8'h00, 8'h34};
    set_base({8'h00, 8'h00, 8'h00, 8'h30});
    fresh_reset();
    bus.in_valid = 4'b0001;
    step(); step(); step();
    bus.out_ready = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      nchk++; if (bus.out_valid !== 1'b1 || bus.out_data !== 8'h31) begin nerr++; $display("FAIL stall_hold[%0d]: got %h/%b expected 31/1", i, bus.out_data, bus.out_valid); end
      nchk++; if (act_ready !== 4'b0000) begin nerr++; $display("FAIL stall_ready[%0d]: got %b expected 0000", i, act_ready); end
    end
    bus.out_ready = 1;
    for (int i = 0; i < 4; i++) begin
      step();
      nchk++; if (bus.out_valid !== ov_t[i]) begin nerr++; $display("FAIL resume_valid[%0d]: got %b expected %b", i, bus.out_valid, ov_t[i]); end
      if (ov_t[i]) begin
        nchk++; if (bus.out_data !== od_t[i]) begin nerr++; $display("FAIL resume_data[%0d]: got %h expected %h", i, bus.out_data, od_t[i]); end
      end
    end
  endtask

  task automatic test_wrap();
    set_base({8'hD0, 8'hC0, 8'hB0, 8'hA0});
    fresh_reset();
    bus.in_valid = 4'b0100;
    step();
    nchk++; if (grant_id !== 2'd2) begin nerr++; $display("FAIL wrap_first: got %0d expected 2", grant_id); end
    step();
    bus.in_valid = 4'b0000;
    step();
    bus.in_valid = 4'b1001;
    step();
    nchk++; if (grant_id !== 2'd3) begin nerr++; $display("FAIL wrap_to_3: got %0d expected 3", grant_id); end
    step();
    nchk++; if (bus.out_data !== 8'hD0) begin nerr++; $display("FAIL wrap_data3: got %h expected d0", bus.out_data); end
    bus.in_valid = 4'b0001;
    step(); step();
    nchk++; if (grant_id !== 2'd0 || busy !== 1'b1) begin nerr++; $display("FAIL wrap_to_0: got id=%0d busy=%b expected 0/1", grant_id, busy); end
  endtask

  task automatic test_reset_mid();
    set_base({8'h00, 8'hE0, 8'h90, 8'h00});
    fresh_reset();
    bus.in_valid = 4'b0010;
    step(); step();
    bus.in_valid = 4'b0000;
    step();
    bus.in_valid = 4'b0100;
    step(); step(); step();
    nchk++; if (bus.out_data !== 8'hE1 || grant_id !== 2'd2) begin nerr++; $display("FAIL mid_pre: got %h id=%0d expected e1 id=2", bus.out_data, grant_id); end
    rst = 1;
    step();
    nchk++; if (bus.out_valid !== 1'b0 || bus.out_data !== 8'h00 || busy !== 1'b0 || grant_id !== 2'd0) begin
      nerr++; $display("FAIL mid_reset: got ov=%b od=%h busy=%b id=%0d expected 0/00/0/0", bus.out_valid, bus.out_data, busy, grant_id);
    end
    rst = 0;
    bus.in_valid = 4'b0110;
    step();
    nchk++; if (act_ready !== 4'b0000) begin nerr++; $display("FAIL mid_ready: got %b expected 0000", act_ready); end
    nchk++; if (grant_id !== 2'd1 || busy !== 1'b1) begin nerr++; $display("FAIL mid_rearb: got id=%0d busy=%b expected 1/1", grant_id, busy); end
  endtask

  task automatic test_random();
    set_base({8'hC0, 8'h80, 8'h40, 8'h00});
    fresh_reset();
    for (int i = 0; i < 3000; i++) begin
      bus.in_valid  = N'($urandom_range(0, 15));
      bus.out_ready = ($urandom_range(0, 3) != 0);
      rst           = ($urandom_range(0, 199) == 0);
      step();
      nchk++; if ({bus.out_valid, busy, grant_id} !== {m_ov, m_busy, GW'(m_gid)}) begin
        nerr++; $display("FAIL rand_ctrl[%0d]: got ov=%b busy=%b id=%0d expected %b/%b/%0d", i, bus.out_valid, busy, grant_id, m_ov, m_busy, m_gid);
      end
      if (m_ov) begin
        nchk++; if (bus.out_data !== m_od) begin nerr++; $display("FAIL rand_data[%0d]: got %h expected %h", i, bus.out_data, m_od); end
      end
      if (i > 0) begin
        nchk++; if (act_ready !== exp_ready) begin nerr++; $display("FAIL rand_ready[%0d]: got %b expected %b", i, act_ready, exp_ready); end
      end
    end
    rst = 0;
  endtask

  initial begin
    bus.in_valid  = '0;
    bus.in_data   = '0;
    bus.out_ready = 1'b1;
    for (int k = 0; k < N; k++) begin
      base[k] = '0;
      cnt[k]  = 0;
    end
    test_reset();
    test_burst_limit();
    test_voluntary();
    test_backpressure();
    test_wrap();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule
